// File: rtl/e_ecc_pkg.sv
// Shared P-256 field definitions: the prime, the default operand width and the
// sequencer state encoding used by the field multiplier and inverter.
package e_ecc_pkg;

    localparam int DEFAULT_WIDTH = 256;

    // p = 2^256 - 2^224 + 2^192 + 2^96 - 1
    localparam logic [255:0] PRIME =
        256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/e_mod_mul_if.sv
// Request/response bundle of the modular multiplier: operands with a start
// pulse in, busy/done handshake and the reduced product out.
interface e_mod_mul_if
    import e_ecc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start_mul;
    logic [WIDTH-1:0] nu_1;
    logic [WIDTH-1:0] nu_2;
    logic             busy;
    logic             done_mul;
    logic [WIDTH-1:0] mul_nu;
    logic             mul_err;

    modport master (
        output start_mul, nu_1, nu_2,
        input  busy, done_mul, mul_nu, mul_err
    );

    modport slave (
        input  start_mul, nu_1, nu_2,
        output busy, done_mul, mul_nu, mul_err
    );
endinterface

// File: rtl/e_mod_add_red.sv
// Combinational (x + y) mod PRIME for reduced inputs x, y < PRIME using a
// single conditional subtraction on a WIDTH+1-bit sum.
module e_mod_add_red
    import e_ecc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum
);
    localparam logic [WIDTH:0] P_EXT = (WIDTH+1)'(PRIME);

    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] red;

    assign raw = {1'b0, x} + {1'b0, y};
    // Result is below 2^WIDTH whenever it is chosen, so the carry bit can be dropped.
    assign red = raw[WIDTH-1:0] - P_EXT[WIDTH-1:0];
    assign sum = (raw >= P_EXT) ? red : raw[WIDTH-1:0];

endmodule

// File: rtl/e_mod_mul.sv
// Bit-serial MSB-first P-256 field multiplier, one multiplier bit per cycle.
// Define E_MOD_MUL_RANGE_CHK_EN to reject unreduced operands via mul_err.
module e_mod_mul
    import e_ecc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        reset_n,
    e_mod_mul_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             start_p0;
    logic [WIDTH-1:0] nu_1_p0;
    logic [WIDTH-1:0] nu_2_p0;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             err_r;

    logic [WIDTH-1:0] acc_dbl;
    logic [WIDTH-1:0] acc_add;
    logic [WIDTH-1:0] acc_next;
    logic             range_bad;

    e_mod_add_red #(.WIDTH(WIDTH)) u_dbl (.x(acc),     .y(acc), .sum(acc_dbl));
    e_mod_add_red #(.WIDTH(WIDTH)) u_add (.x(acc_dbl), .y(a),   .sum(acc_add));

    assign acc_next = b[cnt] ? acc_add : acc_dbl;

`ifdef E_MOD_MUL_RANGE_CHK_EN
    assign range_bad = (a >= WIDTH'(PRIME)) || (b >= WIDTH'(PRIME));
`else
    assign range_bad = 1'b0;
`endif

    // Input register stage: the sequencer only ever sees these copies
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_p0 <= 1'b0;
            nu_1_p0  <= '0;
            nu_2_p0  <= '0;
        end else begin
            start_p0 <= bus.start_mul;
            nu_1_p0  <= bus.nu_1;
            nu_2_p0  <= bus.nu_2;
        end
    end

    // Sequencer stage: latch, reduce bit by bit, publish result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            a            <= '0;
            b            <= '0;
            acc          <= '0;
            cnt          <= '0;
            err_r        <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done_mul <= 1'b0;
            bus.mul_nu   <= '0;
            bus.mul_err  <= 1'b0;
        end else begin
            bus.done_mul <= 1'b0;
            case (state)
                IDLE: begin
                    // busy stays up through the done cycle and falls here unless a new op starts
                    bus.busy <= start_p0;
                    if (start_p0) begin
                        state <= LOAD;
                        a     <= nu_1_p0;
                        b     <= nu_2_p0;
                        acc   <= '0;
                        cnt   <= CNT_W'(WIDTH - 1);
                    end
                end
                LOAD: begin
                    err_r <= range_bad;
                    state <= range_bad ? DONE : CALC;
                end
                CALC: begin
                    acc <= acc_next;
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - 1'b1;
                end
                DONE: begin
                    bus.done_mul <= 1'b1;
                    bus.mul_nu   <= err_r ? '0 : acc;
                    bus.mul_err  <= err_r;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mod_mul.sv
// Self-checking bench for e_mod_mul: directed corners plus random operands
// compared against a wide-integer a*b mod p reference.
module tb_e_mod_mul;
    import e_ecc_pkg::*;

    localparam int W   = DEFAULT_WIDTH;
    localparam int LAT = W + 3;
    localparam logic [W-1:0] P = W'(PRIME);

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   passed = 0;

    e_mod_mul_if #(.WIDTH(W)) bus ();

    e_mod_mul #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_fe();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return W'({1'b0, r} % {1'b0, P});
    endfunction

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return W'(prod % {{W{1'b0}}, P});
    endfunction

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        bus.nu_1      = x;
        bus.nu_2      = y;
        bus.start_mul = 1'b1;
        @(posedge clk); #1;
        bus.start_mul = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk); #1;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done_mul) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.start_mul = 1'b0;
        bus.nu_1      = '0;
        bus.nu_2      = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done_mul, bus.mul_err} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done_mul, bus.mul_err});
        else passed++;
        checks++;
        if (bus.mul_nu !== '0) $display("FAIL reset_mul_nu: got %h expected 0", bus.mul_nu);
        else passed++;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus.busy);
        else passed++;
    endtask

    task automatic test_one();
        int   lat;
        logic bok;
        start_op(W'(1), W'(1));
        wait_done(LAT + 10, lat, bok);
        checks++;
        if (lat !== LAT) $display("FAIL one_latency: got %0d expected %0d", lat, LAT);
        else passed++;
        checks++;
        if (bus.mul_nu !== W'(1) || bus.mul_err !== 1'b0)
            $display("FAIL one_result: got %h err %b expected 1 err 0", bus.mul_nu, bus.mul_err);
        else passed++;
        checks++;
        if (bok !== 1'b1) $display("FAIL one_busy: got busy_ok %b expected 1", bok);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if ({bus.done_mul, bus.busy} !== 2'b00 || bus.mul_nu !== W'(1))
            $display("FAIL one_after: got done %b busy %b nu %h expected 0 0 1",
                     bus.done_mul, bus.busy, bus.mul_nu);
        else passed++;
    endtask

    task automatic test_corners();
        logic [W-1:0] xa [4];
        logic [W-1:0] xb [4];
        logic [W:0]   p1;
        int           lat;
        logic         bok;
        p1 = {1'b0, P} + 1'b1;
        xa[0] = P - 1'b1;  xb[0] = P - 1'b1;
        xa[1] = p1[W:1];   xb[1] = W'(2);
        xa[2] = W'(16'h1234); xb[2] = '0;
        xa[3] = '0;        xb[3] = rand_fe();
        for (int i = 0; i < 4; i++) begin
            start_op(xa[i], xb[i]);
            wait_done(LAT + 10, lat, bok);
            checks++;
            if (lat !== LAT || bok !== 1'b1)
                $display("FAIL corner%0d_timing: got lat %0d busy_ok %b expected %0d 1", i, lat, bok, LAT);
            else passed++;
            checks++;
            if (bus.mul_nu !== ref_mul(xa[i], xb[i]) || bus.mul_err !== 1'b0)
                $display("FAIL corner%0d_result: got %h err %b expected %h err 0",
                         i, bus.mul_nu, bus.mul_err, ref_mul(xa[i], xb[i]));
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        int           lat;
        logic         bok;
        for (int i = 0; i < 6; i++) begin
            x = rand_fe();
            y = rand_fe();
            start_op(x, y);
            wait_done(LAT + 10, lat, bok);
            checks++;
            if (lat !== LAT || bus.mul_nu !== ref_mul(x, y))
                $display("FAIL random%0d: got lat %0d nu %h expected lat %0d nu %h",
                         i, lat, bus.mul_nu, LAT, ref_mul(x, y));
            else passed++;
            repeat (1 + $urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] x, y;
        int           lat;
        logic         bok;
        x = rand_fe();
        y = rand_fe();
        start_op(x, y);
        repeat (100) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done_mul, bus.mul_err} !== 3'b000 || bus.mul_nu !== '0)
            $display("FAIL rstmid_outputs: got busy %b done %b err %b nu %h expected all 0",
                     bus.busy, bus.done_mul, bus.mul_err, bus.mul_nu);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_done(LAT + 10, lat, bok);
        checks++;
        if (lat !== -1) $display("FAIL rstmid_no_done: got done at %0d expected none", lat);
        else passed++;
        x = rand_fe();
        y = rand_fe();
        start_op(x, y);
        wait_done(LAT + 10, lat, bok);
        checks++;
        if (lat !== LAT || bus.mul_nu !== ref_mul(x, y))
            $display("FAIL rstmid_fresh: got lat %0d nu %h expected lat %0d nu %h",
                     lat, bus.mul_nu, LAT, ref_mul(x, y));
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_busy_ignore();
        logic [W-1:0] x1, y1, x2, y2;
        int           lat;
        logic         bok;
        x1 = rand_fe(); y1 = rand_fe();
        x2 = rand_fe(); y2 = rand_fe();
        start_op(x1, y1);
        repeat (9) @(posedge clk);
        #1;
        start_op(x2, y2);
        wait_done(LAT + 10, lat, bok);
        checks++;
        if (lat + 10 !== LAT || bus.mul_nu !== ref_mul(x1, y1))
            $display("FAIL busy_ignore_first: got edge %0d nu %h expected edge %0d nu %h",
                     lat + 10, bus.mul_nu, LAT, ref_mul(x1, y1));
        else passed++;
        wait_done(LAT + 10, lat, bok);
        checks++;
        if (lat !== -1) $display("FAIL busy_ignore_extra: got done at %0d expected none", lat);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x1, y1, x2, y2;
        int           lat;
        logic         bok;
        x1 = rand_fe(); y1 = rand_fe();
        x2 = rand_fe(); y2 = rand_fe();
        start_op(x1, y1);
        repeat (LAT - 1) @(posedge clk);
        #1;
        // second request is sampled on the same edge that raises the first done
        start_op(x2, y2);
        checks++;
        if (bus.done_mul !== 1'b1 || bus.mul_nu !== ref_mul(x1, y1))
            $display("FAIL b2b_first: got done %b nu %h expected 1 nu %h",
                     bus.done_mul, bus.mul_nu, ref_mul(x1, y1));
        else passed++;
        wait_done(LAT + 10, lat, bok);
        checks++;
        if (lat !== LAT || bus.mul_nu !== ref_mul(x2, y2) || bok !== 1'b1)
            $display("FAIL b2b_second: got lat %0d nu %h busy_ok %b expected lat %0d nu %h 1",
                     lat, bus.mul_nu, bok, LAT, ref_mul(x2, y2));
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_range();
        int   lat;
        logic bok;
        start_op(P, W'(5));
        wait_done(LAT + 10, lat, bok);
`ifdef E_MOD_MUL_RANGE_CHK_EN
        checks++;
        if (lat !== 3 || bus.mul_err !== 1'b1 || bus.mul_nu !== '0)
            $display("FAIL range_a: got lat %0d err %b nu %h expected 3 1 0", lat, bus.mul_err, bus.mul_nu);
        else passed++;
        @(posedge clk); #1;
        start_op(W'(3), P + W'(2));
        wait_done(LAT + 10, lat, bok);
        checks++;
        if (lat !== 3 || bus.mul_err !== 1'b1 || bus.mul_nu !== '0)
            $display("FAIL range_b: got lat %0d err %b nu %h expected 3 1 0", lat, bus.mul_err, bus.mul_nu);
        else passed++;
        @(posedge clk); #1;
        start_op(W'(7), W'(9));
        wait_done(LAT + 10, lat, bok);
        checks++;
        if (lat !== LAT || bus.mul_err !== 1'b0 || bus.mul_nu !== W'(63))
            $display("FAIL range_clear: got lat %0d err %b nu %h expected %0d 0 3f",
                     lat, bus.mul_err, bus.mul_nu, LAT);
        else passed++;
`else
        checks++;
        if (lat !== LAT || bus.mul_err !== 1'b0)
            $display("FAIL range_off: got lat %0d err %b expected %0d 0", lat, bus.mul_err, LAT);
        else passed++;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_one();
        test_corners();
        test_random();
        test_reset_mid();
        test_busy_ignore();
        test_back_to_back();
        test_range();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/e_mod_mul.md
E_MOD_MUL -- requirements
Module: e_mod_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 256, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start_mul  input  1  single-cycle request pulse.
REQ-005 SHALL have port nu_1  input  WIDTH  multiplicand a, captured with start_mul.
REQ-006 SHALL have port nu_2  input  WIDTH  multiplier b, captured with start_mul.
REQ-007 SHALL have port busy  output  1  high from capture until done_mul cycle inclusive.
REQ-008 SHALL have port done_mul  output  1  one-cycle completion pulse.
REQ-009 SHALL have port mul_nu  output  WIDTH  result a*b mod PRIME, valid when done_mul=1, held until next done_mul.
REQ-010 SHALL have port mul_err  output  1  operand range error, valid with done_mul.

Function
REQ-011 SHALL compute mul_nu = (nu_1 * nu_2) mod PRIME, PRIME = P-256 field prime 2^256-2^224+2^192+2^96-1.
REQ-012 SHALL register start_mul, nu_1, nu_2 on every edge; the FSM acts on the registered copies.
REQ-013 SHALL implement FSM states IDLE, LOAD, CALC, DONE.
REQ-014 IDLE: on registered start -> LOAD; acc cleared, a/b latched, bit counter = WIDTH-1.
REQ-015 LOAD -> CALC (or DONE directly on range error, see REQ-027).
REQ-016 CALC: one multiplier bit per cycle, MSB first: acc = (2*acc) mod PRIME, then if b[i] acc = (acc + a) mod PRIME, both reductions in the same cycle.
REQ-017 Each reduction SHALL use one conditional subtract of PRIME on a WIDTH+1-bit intermediate; acc SHALL stay in [0, PRIME-1].
REQ-018 CALC SHALL last exactly WIDTH cycles; at counter = 0 -> DONE.
REQ-019 DONE: done_mul=1 for one cycle, mul_nu loaded from acc, -> IDLE.
REQ-020 done_mul SHALL assert exactly WIDTH+3 edges after the edge sampling start_mul (259 for WIDTH=256).
REQ-021 start_mul while busy=1 SHALL be ignored (no restart, no queueing).
REQ-022 start_mul in the DONE cycle SHALL be accepted; back-to-back throughput one op per WIDTH+3 cycles.
REQ-023 Operands a=0 or b=0 SHALL still take full latency and return 0.

Reset
REQ-024 reset_n low SHALL asynchronously force state IDLE, busy=0, done_mul=0, mul_err=0, mul_nu=0, acc=0, counter=0, registered inputs=0.
REQ-025 Reset mid-operation SHALL abort it with no done_mul pulse; first start after release SHALL behave as from power-up.

Configuration
REQ-026 Macro E_MOD_MUL_RANGE_CHK_EN SHALL select the operand range check.
REQ-027 With it defined: if latched a>=PRIME or b>=PRIME, LOAD -> DONE, done_mul asserts 3 edges after sampling, mul_err=1, mul_nu=0.
REQ-028 Without it: no check, operands assumed reduced, mul_err tied 0, port retained.

Structure
REQ-029 Shared package e_ecc_pkg SHALL hold PRIME, default WIDTH and the FSM state enum; shared with e_mod_inv users.
REQ-030 One sub-module e_mod_add_red SHALL implement (x+y) mod PRIME for x,y<PRIME, instantiated twice (double, add).

Verification
REQ-031 a=1, b=1 -> done_mul at edge 259, mul_nu=1, mul_err=0.
REQ-032 a=PRIME-1, b=PRIME-1 -> mul_nu=1; a=(PRIME+1)/2, b=2 -> mul_nu=1.
REQ-033 a=0x1234, b=0 -> mul_nu=0 after full 259-edge latency.
REQ-034 start at t, second start at t+10 -> single done_mul, result of first operands only.
REQ-035 reset_n pulsed low at edge 100 of an op -> no done_mul, all outputs 0; fresh op then correct.
REQ-036 With E_MOD_MUL_RANGE_CHK_EN, a=PRIME, b=5 -> done_mul at edge 3, mul_err=1, mul_nu=0; without it, mul_err stays 0.
